// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
// Imported by the register file top and its scoreboard.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_word_t;

  localparam rf_addr_t RF_ZERO_IDX = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for pending multi-cycle writebacks.
// Issue sets, committed writes clear, issue wins on a tie.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int N_WR     = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_WR-1:0]        wr_vld,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(RF_ZERO_IDX);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] clr;
  logic             iss_vld;

  assign iss_vld = iss_en & rst_n & ~(ZR && iss_addr == ZIDX);

  // Clear on any committed write, then let a new issue re-arm.
  always_comb begin
    clr = '0;
    for (int j = 0; j < N_WR; j++) begin
      if (wr_vld[j]) clr[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
    end
    busy_d = busy_q & ~clr;
    if (iss_vld) busy_d[iss_addr] = 1'b1;
  end

  // Busy vector; reset drops every pending producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hide;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
    // A same-cycle writeback hides busy unless a new issue re-targets it.
    always_comb begin
      hide = clr[ra] & ~(iss_vld && iss_addr == ra);
      if (ZR && ra == ZIDX) hide = 1'b1;
    end
    assign rd_busy[i] = busy_q[ra] & ~hide;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-first bypass and zero register.
// Busy tracking lives in rf_scoreboard.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int N_WR     = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(RF_ZERO_IDX);

  if (N_RD < 1 || N_RD > 4 || N_WR < 1 || N_WR > 2) begin : g_bad
    $error("reg_file_mp: N_RD must be 1..4 and N_WR 1..2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [N_WR-1:0]   wr_vld;

  for (genvar j = 0; j < N_WR; j++) begin : g_wr
    logic [ADDR_W-1:0] wa;
    assign wa = wr_addr[j*ADDR_W +: ADDR_W];
    assign wr_vld[j] = wr_en[j] & rst_n & ~(ZR && wa == ZIDX);
  end

  // Storage; later ports overwrite earlier ones on address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      for (int j = 0; j < N_WR; j++) begin
        if (wr_vld[j])
          mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
    // Write-first read: highest matching write port wins over storage.
    always_comb begin
      d = mem[ra];
      for (int j = 0; j < N_WR; j++) begin
        if (wr_vld[j] && wr_addr[j*ADDR_W +: ADDR_W] == ra)
          d = wr_data[j*DATA_W +: DATA_W];
      end
      if (ZR && ra == ZIDX) d = '0;
    end
    assign rd_data[i*DATA_W +: DATA_W] = d;
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .N_RD    (N_RD),
    .N_WR    (N_WR),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_vld  (wr_vld),
    .wr_addr (wr_addr),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy)
  );

endmodule
